// File: rtl/foc_pkg.sv
// rtl/foc_pkg.sv - shared FOC payload layout, tag type and datapath latency default
package foc_pkg;

  localparam int ALPHA_LSB     = 0;
  localparam int BETA_LSB      = 16;
  localparam int THETA_LSB     = 32;
  localparam int VA_LSB        = 0;
  localparam int VB_LSB        = 16;
  localparam int VC_LSB        = 32;
  localparam int THETA_OUT_LSB = 48;

  localparam int DP_LAT_DEF = 3;
  // Channel index width sized for the largest supported channel count (8).
  localparam int CH_W = 3;

  typedef struct packed {
    logic            vld;
    logic [CH_W-1:0] ch;
  } tag_t;

endpackage

// File: rtl/clarke_inv_sched_rr_arbiter.sv
// rtl/clarke_inv_sched_rr_arbiter.sv - combinational round-robin arbiter, search starts after i_ptr
module rr_arbiter
  import foc_pkg::*;
#(
  parameter int N_CH = 4
) (
  input  logic [N_CH-1:0] i_req,
  input  logic [CH_W-1:0] i_ptr,
  output logic [N_CH-1:0] o_gnt,
  output logic [CH_W-1:0] o_idx,
  output logic            o_any
);

  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    // Offset k=N_CH revisits the pointer channel itself, last in priority.
    for (int k = 1; k <= N_CH; k++) begin
      for (int c = 0; c < N_CH; c++) begin
        if (!o_any && i_req[c] && (c == (int'(i_ptr) + k) % N_CH)) begin
          o_gnt[c] = 1'b1;
          o_idx    = CH_W'(c);
          o_any    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/clarke_inv_sched.sv
// rtl/clarke_inv_sched.sv - shares one inverse-Clarke datapath across N_CH channels
// Optional statistics counters: CLARKE_INV_SCHED_STATS_EN
module clarke_inv_sched
  import foc_pkg::*;
#(
  parameter int N_CH   = 4,
  parameter int DP_LAT = DP_LAT_DEF
`ifdef CLARKE_INV_SCHED_STATS_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [N_CH-1:0]      req_valid,
  input  logic [N_CH*64-1:0]   req_data,
  output logic [N_CH-1:0]      req_ready,
  output logic [N_CH-1:0]      rsp_valid,
  output logic [N_CH*64-1:0]   rsp_data,
  input  logic [N_CH-1:0]      rsp_ready,
  output logic                 dp_enable,
  output logic [63:0]          dp_s_axis,
  input  logic [63:0]          dp_m_axis
`ifdef CLARKE_INV_SCHED_STATS_EN
  , output logic [N_CH*CNT_W-1:0] grant_cnt
  , output logic [CNT_W-1:0]      stall_cnt
`endif
);

  logic [N_CH-1:0]    r_busy;
  logic [N_CH-1:0]    r_rsp_valid;
  logic [N_CH*64-1:0] r_rsp_data;
  logic [CH_W-1:0]    r_ptr;
  tag_t               r_tag [DP_LAT];

  logic [N_CH-1:0]    w_elig;
  logic [N_CH-1:0]    w_gnt;
  logic [N_CH-1:0]    w_cap;
  logic [CH_W-1:0]    w_gnt_idx;
  logic               w_gnt_any;
  tag_t               w_tail;

  assign w_elig = req_valid & ~r_busy & ~r_rsp_valid & {N_CH{en}};
  assign w_tail = r_tag[DP_LAT-1];

  rr_arbiter #(.N_CH(N_CH)) u_arb (
    .i_req (w_elig),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_gnt_idx),
    .o_any (w_gnt_any)
  );

  always_comb begin
    dp_s_axis = '0;
    w_cap     = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (w_gnt[i]) dp_s_axis = req_data[64*i +: 64];
      w_cap[i] = en && w_tail.vld && (w_tail.ch == CH_W'(i));
    end
  end

  assign req_ready = w_gnt;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign dp_enable = en;

  // Tag pipe mirrors the datapath stages so the tail lines up with dp_m_axis.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < DP_LAT; s++) r_tag[s] <= '0;
      r_ptr <= CH_W'(N_CH - 1);
    end else if (en) begin
      r_tag[0] <= {w_gnt_any, w_gnt_idx};
      for (int s = 1; s < DP_LAT; s++) r_tag[s] <= r_tag[s-1];
      if (w_gnt_any) r_ptr <= w_gnt_idx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy      <= '0;
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (w_gnt[i]) r_busy[i] <= 1'b1;
        else if (w_cap[i]) r_busy[i] <= 1'b0;

        if (w_cap[i]) begin
          r_rsp_valid[i]         <= 1'b1;
          r_rsp_data[64*i +: 64] <= dp_m_axis;
        end else if (r_rsp_valid[i] && rsp_ready[i]) begin
          r_rsp_valid[i] <= 1'b0;
        end
      end
    end
  end

`ifdef CLARKE_INV_SCHED_STATS_EN
  logic [N_CH*CNT_W-1:0] r_grant_cnt;
  logic [CNT_W-1:0]      r_stall_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_grant_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (w_gnt[i] && (r_grant_cnt[CNT_W*i +: CNT_W] != {CNT_W{1'b1}}))
          r_grant_cnt[CNT_W*i +: CNT_W] <= r_grant_cnt[CNT_W*i +: CNT_W] + 1'b1;
      end
      if ((|(req_valid & ~w_gnt)) && (r_stall_cnt != {CNT_W{1'b1}}))
        r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign grant_cnt = r_grant_cnt;
  assign stall_cnt = r_stall_cnt;
`endif

endmodule
